instruction_fetch_unit: RTL and testbench

- Requester side of the instruction memory read interface.
- Drives a word address into the multi-core instruction memory and captures the CORES×32-bit bundle returned one cycle later.
- Buffers returned bundles, tagged with their PC, in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports sequential fetch, stall via backpressure, and branch redirect with flush.

---
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle: instruction memory request/response, redirect, and decode valid/ready.
// master = fetch unit, slave = memory/decode/control side.
interface instruction_fetch_unit_if #(
    parameter int CORES      = 1,
    parameter int ADDR_WIDTH = 32
);
    logic                    fetch_en;
    logic [ADDR_WIDTH-1:0]   imem_address;
    logic [32*CORES-1:0]     imem_data;
    logic                    redirect;
    logic [ADDR_WIDTH-1:0]   redirect_pc;
    logic                    instr_valid;
    logic                    instr_ready;
    logic [32*CORES-1:0]     instr_out;
    logic [ADDR_WIDTH-1:0]   instr_pc;
    logic [31:0]             perf_fetched;
    logic [31:0]             perf_stalls;

    modport master (
        input  fetch_en, imem_data, redirect, redirect_pc, instr_ready,
        output imem_address, instr_valid, instr_out, instr_pc, perf_fetched, perf_stalls
    );

    modport slave (
        output fetch_en, imem_data, redirect, redirect_pc, instr_ready,
        input  imem_address, instr_valid, instr_out, instr_pc, perf_fetched, perf_stalls
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issue to imem, bundle valid to decode 2 cycles later; credit-limited issue so decode stalls never overflow the buffer.
// Optional perf counters behind FETCH_PERF_EN (tied to 0 when undefined).
module instruction_fetch_unit #(
    parameter int                    CORES      = 1,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_unit_if.master   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [32*CORES-1:0]   r_fifo_dat [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc  [FIFO_DEPTH];

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [OCC_W-1:0]      w_occupancy;

    always_comb begin
        w_valid     = (r_count != '0);
        w_pop       = w_valid & bus.instr_ready;
        // Slots committed after this cycle: entries kept plus the response on its way.
        w_occupancy = OCC_W'(r_count) - OCC_W'(w_pop) + OCC_W'(r_inflight);
        w_issue     = bus.fetch_en & ~bus.redirect & (w_occupancy < OCC_W'(FIFO_DEPTH));
        w_push      = r_inflight & ~bus.redirect;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (bus.redirect) begin
            r_pc       <= bus.redirect_pc;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_pc          <= r_pc + ADDR_WIDTH'(1);
                r_inflight_pc <= r_pc;
            end
            r_inflight <= w_issue;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_fifo_dat[r_wr_ptr] <= bus.imem_data;
            r_fifo_pc[r_wr_ptr]  <= r_inflight_pc;
        end
    end

    assign bus.imem_address = r_pc;
    assign bus.instr_valid  = w_valid;
    assign bus.instr_out    = r_fifo_dat[r_rd_ptr];
    assign bus.instr_pc     = r_fifo_pc[r_rd_ptr];

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (bus.fetch_en && !bus.redirect && !w_issue) r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign bus.perf_fetched = r_perf_fetched;
    assign bus.perf_stalls  = r_perf_stalls;
`else
    assign bus.perf_fetched = 32'd0;
    assign bus.perf_stalls  = 32'd0;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed phases plus random traffic checked against a queue model.
module tb_instruction_fetch_unit;
    logic clk;
    logic reset;
    logic rst_w;

    instruction_fetch_unit_if #(.CORES(2), .ADDR_WIDTH(32)) bus  ();
    instruction_fetch_unit_if #(.CORES(1), .ADDR_WIDTH(8))  busw ();

    instruction_fetch_unit #(
        .CORES(2), .ADDR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instruction_fetch_unit #(
        .CORES(1), .ADDR_WIDTH(8), .FIFO_DEPTH(4), .RESET_PC(8'hFF)
    ) dut_w (
        .clk   (clk),
        .reset (rst_w),
        .bus   (busw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem2(input logic [31:0] a);
        if (a == 32'd1) return 64'hBBBBBBBB_AAAAAAAA;
        return {a ^ 32'h5A5A_0000, a};
    endfunction

    function automatic logic [31:0] mem1(input logic [7:0] a);
        return 32'hC0DE_0000 | {24'h0, a};
    endfunction

    always @(posedge clk) begin
        bus.imem_data  <= mem2(bus.imem_address);
        busw.imem_data <= mem1(busw.imem_address);
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_pc[$];
    logic [31:0] m_pc       = 32'h0;
    logic [31:0] m_infl_pc  = 32'h0;
    bit          m_infl     = 1'b0;
    logic [31:0] m_fetched  = 32'h0;
    logic [31:0] m_stalls   = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outputs();
        chk("valid", 64'(bus.instr_valid), 64'(q_pc.size() > 0));
        if (q_pc.size() > 0) begin
            chk("instr_pc", 64'(bus.instr_pc), 64'(q_pc[0]));
            chk("instr_out", bus.instr_out, mem2(q_pc[0]));
            if (q_pc[0] == 32'd1) chk("two_core_bundle", bus.instr_out, 64'hBBBBBBBB_AAAAAAAA);
        end
        chk("imem_address", 64'(bus.imem_address), 64'(m_pc));
`ifdef FETCH_PERF_EN
        chk("perf_fetched", 64'(bus.perf_fetched), 64'(m_fetched));
        chk("perf_stalls", 64'(bus.perf_stalls), 64'(m_stalls));
`else
        chk("perf_fetched", 64'(bus.perf_fetched), 64'h0);
        chk("perf_stalls", 64'(bus.perf_stalls), 64'h0);
`endif
    endtask

    // Behavioural model: queue of buffered PCs, at most one outstanding read.
    task automatic model_step(input bit rst, input bit fe, input bit rdy, input bit redir,
                              input logic [31:0] rpc);
        bit pop;
        bit issue;
        int occ;
        if (rst) begin
            q_pc.delete();
            m_pc = 32'h0; m_infl = 1'b0; m_fetched = 32'h0; m_stalls = 32'h0;
            return;
        end
        pop   = (q_pc.size() > 0) && rdy;
        occ   = q_pc.size() - int'(pop) + int'(m_infl);
        issue = fe && !redir && (occ < 4);
        if (fe && !redir && !issue) m_stalls++;
        if (redir) begin
            q_pc.delete();
            m_pc   = rpc;
            m_infl = 1'b0;
            return;
        end
        if (pop) void'(q_pc.pop_front());
        if (m_infl) begin
            q_pc.push_back(m_infl_pc);
            m_fetched++;
        end
        if (issue) begin
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd1;
        end
        m_infl = issue;
    endtask

    task automatic cyc(input bit rst, input bit fe, input bit rdy, input bit redir,
                       input logic [31:0] rpc);
        check_outputs();
        reset           = rst;
        bus.fetch_en    = fe;
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        model_step(rst, fe, rdy, redir, rpc);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        rst_w = 1'b1;
        bus.fetch_en = 1'b0;  bus.instr_ready = 1'b0;  bus.redirect = 1'b0;  bus.redirect_pc = '0;
        busw.fetch_en = 1'b0; busw.instr_ready = 1'b1; busw.redirect = 1'b0; busw.redirect_pc = '0;
        repeat (3) @(negedge clk);

        // Wrap: 8-bit PC starting at all-ones, then reset mid-stream.
        rst_w = 1'b0; busw.fetch_en = 1'b1;
        chk("wrap_addr0", 64'(busw.imem_address), 64'hFF);
        chk("wrap_valid0", 64'(busw.instr_valid), 64'h0);
        tick();
        chk("wrap_addr1", 64'(busw.imem_address), 64'h00);
        chk("wrap_valid1", 64'(busw.instr_valid), 64'h0);
        tick();
        chk("wrap_valid2", 64'(busw.instr_valid), 64'h1);
        chk("wrap_pc_ff", 64'(busw.instr_pc), 64'hFF);
        chk("wrap_dat_ff", 64'(busw.instr_out), 64'hC0DE00FF);
        tick();
        chk("wrap_valid3", 64'(busw.instr_valid), 64'h1);
        chk("wrap_pc_00", 64'(busw.instr_pc), 64'h00);
        chk("wrap_dat_00", 64'(busw.instr_out), 64'hC0DE0000);
        rst_w = 1'b1;
        tick();
        chk("wrap_rst_valid", 64'(busw.instr_valid), 64'h0);
        chk("wrap_rst_addr", 64'(busw.imem_address), 64'hFF);
        busw.fetch_en = 1'b0;

        // Streaming from reset.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0);

        // Backpressure from reset: buffer fills, PC parks at 4.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
        chk("bp_pc_parked", 64'(bus.imem_address), 64'd4);
        chk("bp_head_pc", 64'(bus.instr_pc), 64'd0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 0);

        // Redirect with three buffered and one read in flight.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 32'h40);
        chk("redir_valid_drop", 64'(bus.instr_valid), 64'h0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("redir_first_valid", 64'(bus.instr_valid), 64'h1);
        chk("redir_first_pc", 64'(bus.instr_pc), 64'h40);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);

        // Perf: stream, then stall decode for six cycles.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
`ifdef FETCH_PERF_EN
        chk("perf_hand_fetched", 64'(bus.perf_fetched), 64'd9);
        chk("perf_hand_stalls", 64'(bus.perf_stalls), 64'd4);
`else
        chk("perf_hand_fetched", 64'(bus.perf_fetched), 64'd0);
        chk("perf_hand_stalls", 64'(bus.perf_stalls), 64'd0);
`endif

        // Random traffic, including rare resets and redirects near the wrap point.
        for (int i = 0; i < 400; i++) begin
            bit          r_rst;
            bit          r_fe;
            bit          r_rdy;
            bit          r_red;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 99) == 0);
            r_fe  = ($urandom_range(0, 3) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_red = ($urandom_range(0, 19) == 0);
            r_pc  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFE : $urandom;
            cyc(r_rst, r_fe, r_rdy, r_red, r_pc);
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
